// File: rtl/hs32_bus_arb.sv
// hs32_bus_arb
// ------------
// Two-master arbiter placed in front of the MMIO unit's single-master request
// bus. The Caravel Wishbone slave port and the HS32 CPU memory port compete
// for the downstream bus. Each transaction runs alone through a four-state
// FSM: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE. When both masters request,
// they are served round-robin. A watchdog forces completion with read data 0
// when the downstream never acknowledges.
//
// Parameters
//   TIMEOUT      maximum WAIT cycle count before forced completion (1..255)
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   hold         1: only Wishbone may be granted; 0: round-robin between both
//   wbs_*_i      Wishbone classic request (cyc, stb, we, sel, adr, dat)
//   wbs_ack_o    Wishbone acknowledge, one-cycle pulse
//   wbs_dat_o    Wishbone read data
//   cpu_stb      CPU request, held by the CPU until cpu_ack
//   cpu_rw       CPU write flag
//   cpu_addr     CPU address
//   cpu_dout     CPU write data
//   cpu_ack      CPU acknowledge, one-cycle pulse
//   cpu_din      CPU read data
//   m_stb        downstream strobe, one-cycle pulse per transaction
//   m_rw         downstream write flag
//   m_addr       downstream address
//   m_dtw        downstream write data
//   m_ack        downstream acknowledge
//   m_dtr        downstream read data, valid with m_ack
//   timeout_o    one-cycle pulse when the watchdog fires
module hs32_bus_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,

    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,

    input  logic        cpu_stb,
    input  logic        cpu_rw,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_dout,
    output logic        cpu_ack,
    output logic [31:0] cpu_din,

    output logic        m_stb,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_dtw,
    input  logic        m_ack,
    input  logic [31:0] m_dtr,

    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    state_t      state;
    state_t      next_state;
    logic [7:0]  wd_cnt;
    logic        owner_wb;
    logic        last_wb;
    logic [31:0] rdata;

    logic        wb_req;
    logic        cpu_req;
    logic        pick_wb;
    logic        dn_ack;
    logic        wd_fire;

    assign wb_req  = wbs_cyc_i & wbs_stb_i;
    assign cpu_req = cpu_stb & ~hold;

    // Wishbone wins when it is the only requester, or on a tie when the CPU
    // was granted last. last_wb resets to 0 (CPU), so Wishbone takes the
    // first tie.
    assign pick_wb = wb_req & (~cpu_req | ~last_wb);

    // Downstream acks are only honoured while a transaction is outstanding,
    // so a late ack after a watchdog completion is dropped.
    assign dn_ack  = m_ack & ((state == ISSUE) | (state == WAIT));
    assign wd_fire = (state == WAIT) & ~m_ack & (wd_cnt == WD_LIMIT);

    assign wbs_dat_o = rdata;
    assign cpu_din   = rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wb_req | cpu_req) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = m_ack ? RESP : WAIT;
            end
            WAIT: begin
                if (m_ack | wd_fire) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Every output is a register loaded one edge ahead of the state it
    // belongs to, so nothing combinational reaches the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_stb     <= 1'b0;
            m_rw      <= 1'b0;
            m_addr    <= 32'h0;
            m_dtw     <= 32'h0;
            wbs_ack_o <= 1'b0;
            cpu_ack   <= 1'b0;
            timeout_o <= 1'b0;
            rdata     <= 32'h0;
            wd_cnt    <= 8'h0;
            owner_wb  <= 1'b0;
            last_wb   <= 1'b0;
        end else begin
            m_stb     <= (state == IDLE) & (wb_req | cpu_req);
            wbs_ack_o <= (dn_ack | wd_fire) & owner_wb;
            cpu_ack   <= (dn_ack | wd_fire) & ~owner_wb;
            timeout_o <= wd_fire;
            wd_cnt    <= (state == WAIT) ? wd_cnt + 8'd1 : 8'h0;

            // The request is captured once here and left untouched until the
            // next grant, keeping m_addr/m_dtw/m_rw stable through RESP.
            if ((state == IDLE) & (wb_req | cpu_req)) begin
                owner_wb <= pick_wb;
                if (pick_wb) begin
                    m_addr <= wbs_adr_i;
                    m_dtw  <= wbs_dat_i;
                    m_rw   <= wbs_we_i & (|wbs_sel_i);
                end else begin
                    m_addr <= cpu_addr;
                    m_dtw  <= cpu_dout;
                    m_rw   <= cpu_rw;
                end
            end

            if (dn_ack) begin
                rdata <= m_dtr;
            end else if (wd_fire) begin
                rdata <= 32'h0;
            end

            if (state == RESP) begin
                last_wb <= owner_wb;
            end
        end
    end

endmodule

// File: tb/tb_hs32_bus_arb.sv
// tb_hs32_bus_arb
// ---------------
// Randomised bench for hs32_bus_arb. Two master processes issue requests, a
// hold process toggles hold, and a downstream responder acks after a random
// delay (sometimes too late, forcing the watchdog). At each grant the
// reference model decides which master should have won from the request
// inputs at the grant edge, and pushes the expected completion (owner, data,
// timeout flag, completion cycle) into a scoreboard queue. A separate monitor
// pops and compares whenever an ack or timeout appears at the outputs.
`timescale 1ns/1ps

module tb_hs32_bus_arb;

    localparam int TMO = 4;
    localparam int N_TXN = 50;

    typedef struct {
        logic        to_wb;
        logic [31:0] data;
        logic        tmo;
        int          ack_cycle;
        logic [31:0] addr;
        logic [31:0] dtw;
        logic        rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cpu_stb, cpu_rw;
    logic [31:0] cpu_addr, cpu_dout;
    logic        cpu_ack;
    logic [31:0] cpu_din;
    logic        m_stb, m_rw;
    logic [31:0] m_addr, m_dtw;
    logic        m_ack;
    logic [31:0] m_dtr;
    logic        timeout_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_cnt = 0;

    exp_t        sb[$];

    int          force_d = -1;
    logic        force_data_en = 1'b0;
    logic [31:0] force_data = 32'h0;
    logic        wb_done = 1'b0;
    logic        cpu_done = 1'b0;

    hs32_bus_arb #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .cpu_stb   (cpu_stb),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .cpu_din   (cpu_din),
        .m_stb     (m_stb),
        .m_rw      (m_rw),
        .m_addr    (m_addr),
        .m_dtw     (m_dtw),
        .m_ack     (m_ack),
        .m_dtr     (m_dtr),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_m_stb"},     32'(m_stb),     32'd0);
        checkOutput({tag, "_m_rw"},      32'(m_rw),      32'd0);
        checkOutput({tag, "_m_addr"},    m_addr,         32'd0);
        checkOutput({tag, "_m_dtw"},     m_dtw,          32'd0);
        checkOutput({tag, "_wbs_ack"},   32'(wbs_ack_o), 32'd0);
        checkOutput({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
        checkOutput({tag, "_wbs_dat"},   wbs_dat_o,      32'd0);
        checkOutput({tag, "_cpu_din"},   cpu_din,        32'd0);
        checkOutput({tag, "_timeout"},   32'(timeout_o), 32'd0);
    endtask

    // Issue one transaction on a master and hold it until that master's ack.
    task automatic applyStimulus(input logic is_wb, input logic [31:0] addr, input logic [31:0] data,
                                 input logic we, input logic [3:0] sel);
        logic got;
        @(negedge clk);
        if (is_wb) begin
            wbs_adr_i = addr;
            wbs_dat_i = data;
            wbs_we_i  = we;
            wbs_sel_i = sel;
            wbs_cyc_i = 1'b1;
            wbs_stb_i = 1'b1;
        end else begin
            cpu_addr = addr;
            cpu_dout = data;
            cpu_rw   = we;
            cpu_stb  = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk);
            #1;
            got = is_wb ? wbs_ack_o : cpu_ack;
        end
        checkOutput(is_wb ? "wb_ack_arrived" : "cpu_ack_arrived", 32'(got), 32'd1);
        @(negedge clk);
        if (is_wb) begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
        end else begin
            cpu_stb = 1'b0;
        end
    endtask

    task automatic wb_loop();
        for (int n = 0; n < N_TXN; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
        end
        wb_done = 1'b1;
    endtask

    task automatic cpu_loop();
        for (int n = 0; n < N_TXN; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'h0);
        end
        cpu_done = 1'b1;
    endtask

    task automatic hold_loop();
        int hi;
        hi = 0;
        while (!(wb_done && cpu_done)) begin
            @(negedge clk);
            hi = hold ? hi + 1 : 0;
            if (hi > 20 || $urandom_range(0, 7) == 0) begin
                hold = ~hold;
                hi = 0;
            end
        end
        hold = 1'b0;
    endtask

    // Downstream responder plus reference model: decides the expected winner
    // at each grant and pushes the expected completion.
    logic        wb_r, cpu_r, win_wb, model_last_wb;
    int          ack_cd, d;
    logic [31:0] pend_data, rd_val;
    exp_t        e;

    initial begin
        m_ack = 1'b0;
        m_dtr = 32'h0;
        ack_cd = 0;
        model_last_wb = 1'b0;
        pend_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                sb.delete();
                ack_cd = 0;
                m_ack = 1'b0;
                model_last_wb = 1'b0;
                continue;
            end
            m_ack = 1'b0;
            m_dtr = $urandom;
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) begin
                    m_ack = 1'b1;
                    m_dtr = pend_data;
                end
            end
            if (m_stb) begin
                wb_r  = wbs_cyc_i & wbs_stb_i;
                cpu_r = cpu_stb & ~hold;
                checkOutput("grant_has_requester", 32'(wb_r | cpu_r), 32'd1);
                checkOutput("no_overlap", 32'(sb.size()), 32'd0);
                win_wb = (wb_r && cpu_r) ? ~model_last_wb : wb_r;
                model_last_wb = win_wb;
                e.to_wb = win_wb;
                e.addr  = win_wb ? wbs_adr_i : cpu_addr;
                e.dtw   = win_wb ? wbs_dat_i : cpu_dout;
                e.rw    = win_wb ? (wbs_we_i & (|wbs_sel_i)) : cpu_rw;
                checkOutput("m_addr_issue", m_addr, e.addr);
                checkOutput("m_dtw_issue", m_dtw, e.dtw);
                checkOutput("m_rw_issue", 32'(m_rw), 32'(e.rw));
                if (force_d >= 0) d = force_d;
                else if ($urandom_range(0, 9) < 7) d = $urandom_range(0, TMO + 1);
                else d = $urandom_range(TMO + 2, TMO + 3);
                rd_val = force_data_en ? force_data : $urandom;
                // Acks d cycles after ISSUE; the window closes at ISSUE+TMO+1.
                if (d <= TMO + 1) begin
                    e.data = rd_val;
                    e.tmo = 1'b0;
                    e.ack_cycle = cyc_cnt + d + 1;
                end else begin
                    e.data = 32'h0;
                    e.tmo = 1'b1;
                    e.ack_cycle = cyc_cnt + TMO + 2;
                end
                sb.push_back(e);
                if (d == 0) begin
                    m_ack = 1'b1;
                    m_dtr = rd_val;
                end else begin
                    ack_cd = d;
                    pend_data = rd_val;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a completion.
    exp_t got_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (wbs_ack_o || cpu_ack || timeout_o) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", 32'({wbs_ack_o, cpu_ack, timeout_o}), 32'd0);
                end else begin
                    got_e = sb[0];
                    sb.delete(0);
                    checkOutput("wbs_ack", 32'(wbs_ack_o), 32'(got_e.to_wb));
                    checkOutput("cpu_ack", 32'(cpu_ack), 32'(!got_e.to_wb));
                    checkOutput("wbs_dat", wbs_dat_o, got_e.data);
                    checkOutput("cpu_din", cpu_din, got_e.data);
                    checkOutput("timeout_o", 32'(timeout_o), 32'(got_e.tmo));
                    checkOutput("ack_cycle", 32'(cyc_cnt), 32'(got_e.ack_cycle));
                    checkOutput("m_addr_resp", m_addr, got_e.addr);
                    checkOutput("m_dtw_resp", m_dtw, got_e.dtw);
                    checkOutput("m_rw_resp", 32'(m_rw), 32'(got_e.rw));
                end
            end else if (sb.size() > 0 && cyc_cnt > sb[0].ack_cycle) begin
                checkOutput("ack_missing", 32'(cyc_cnt), 32'(sb[0].ack_cycle));
                sb.delete(0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got cycle %0d", cyc_cnt);
        $fatal(1, "[TB] stopping");
    end

    logic got_stb;
    initial begin
        rst = 1'b1;
        hold = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        cpu_stb = 1'b0; cpu_rw = 1'b0; cpu_addr = 32'h0; cpu_dout = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("init");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed Wishbone read under hold");
        hold = 1'b1;
        force_d = 1;
        force_data_en = 1'b1;
        force_data = 32'hCAFE_F00D;
        applyStimulus(1'b1, 32'h0000_0010, 32'h0, 1'b0, 4'hF);

        $display("[TB] directed CPU write");
        hold = 1'b0;
        force_data = 32'h0BAD_BEEF;
        applyStimulus(1'b0, 32'h0000_0020, 32'h1234_5678, 1'b1, 4'h0);

        $display("[TB] directed timeout");
        force_d = TMO + 3;
        applyStimulus(1'b1, 32'h0000_0030, 32'h0, 1'b0, 4'hF);
        force_d = -1;
        force_data_en = 1'b0;

        $display("[TB] random traffic");
        fork
            wb_loop();
            cpu_loop();
            hold_loop();
        join
        repeat (15) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] reset during WAIT");
        force_d = TMO + 3;
        @(negedge clk);
        wbs_adr_i = 32'h40; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        got_stb = 1'b0;
        for (int i = 0; i < 20 && !got_stb; i++) begin
            @(posedge clk);
            #1;
            got_stb = m_stb;
        end
        checkOutput("rst_test_grant", 32'(got_stb), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("mid");
        @(negedge clk);
        rst = 1'b0;
        force_d = 1;
        applyStimulus(1'b1, 32'h44, 32'h0, 1'b0, 4'hF);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("sb_final", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
